// File: rtl/optical_rx_deserializer_pkg.sv
// Shared definitions for the optical receive path: FSM state encoding and default bit timing.
package optical_rx_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/optical_rx_deserializer_if.sv
// Output bus of the optical deserializer toward the PIO/status logic, plus the error-clear strobe.
interface optical_rx_if #(
    parameter int DATA_W = 8
);
    // rx_valid is a one-cycle strobe with no ready: it marks the cycle rx_byte takes a new
    // value; rx_byte itself is static between strobes, so a consumer may read it any time.
    logic [DATA_W-1:0] rx_byte;
    logic              rx_valid;
    logic [7:0]        rx_count;
    logic              frame_err;
    logic              busy;
    logic [1:0]        state;
    logic              err_clr;

    modport master (
        output rx_byte, rx_valid, rx_count, frame_err, busy, state,
        input  err_clr
    );

    modport slave (
        input  rx_byte, rx_valid, rx_count, frame_err, busy, state,
        output err_clr
    );
endinterface

// File: rtl/optical_rx_deserializer_sync.sv
// Multi-flop synchronizer for asynchronous optical pins; reset value selectable so idle lines stay quiet.
module optical_rx_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], async_in};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync_out = chain_q[STAGES-1];

endmodule

// File: rtl/optical_rx_deserializer.sv
// 8N1 receiver for the optical serial line: synchronizes the pin, frames bytes, and holds the last good byte.
module optical_rx_deserializer
    import optical_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_serial,
    optical_rx_if.master bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    logic rx_s;
    logic rx_s_prev_q, rx_s_prev_d;
    logic fall;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
    logic              rx_valid_q, rx_valid_d;
    logic [7:0]        rx_count_q, rx_count_d;
    logic              frame_err_q, frame_err_d;

    optical_rx_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (rx_serial),
        .sync_out (rx_s)
    );

    assign rx_s_prev_d = rx_s;
    assign fall        = rx_s_prev_q & ~rx_s;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        rx_count_d  = rx_count_q;
        frame_err_d = frame_err_q;

        // Clear first so a stop-bit error in the same cycle overrides it.
        if (bus.err_clr) begin
            frame_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (bit_cnt_q == HALF_M1) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_cnt_q == FULL_M1) begin
                    shift_d[bit_idx_q] = rx_s;
                    bit_cnt_d          = '0;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_cnt_q == FULL_M1) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                    if (rx_s) begin
                        rx_byte_d  = shift_q;
                        rx_valid_d = 1'b1;
                        rx_count_d = rx_count_q + 8'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_s_prev_q <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_count_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_s_prev_q <= rx_s_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            rx_count_q  <= rx_count_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.rx_byte   = rx_byte_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.rx_count  = rx_count_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state     = state_q;

endmodule

// File: tb/tb_optical_rx_deserializer.sv
// Directed bench for the optical deserializer at 16 clocks per bit.
module tb_optical_rx_deserializer;
    import optical_rx_pkg::*;

    localparam int BIT = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx_serial = 1'b1;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    logic [7:0] last_valid_byte = 8'h00;
    int snap;
    bit found;

    optical_rx_if #(.DATA_W(8)) bus ();

    optical_rx_deserializer #(
        .CLKS_PER_BIT (BIT),
        .DATA_W       (8),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_serial (rx_serial),
        .bus       (bus.master)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // rx_valid monitor: counts high cycles and captures the byte shown with each strobe
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) begin
            valid_cnt++;
            last_valid_byte = bus.rx_byte;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        rx_serial = 1'b1;
        idle(3);
        reset_n = 1'b1;
        idle(4);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_serial = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            idle(BIT);
        end
        rx_serial = stop_bit;
        idle(BIT);
        rx_serial = 1'b1;
    endtask

    initial begin
        bus.err_clr = 1'b0;
        idle(3);
        #1;
        check("reset_byte", 32'(bus.rx_byte), 32'h00);
        check("reset_count", 32'(bus.rx_count), 32'd0);
        check("reset_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_ferr", 32'(bus.frame_err), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(8);

        // 1: single good frame
        snap = valid_cnt;
        send_frame(8'hA5, 1'b1);
        idle(BIT);
        check("t1_byte", 32'(bus.rx_byte), 32'hA5);
        check("t1_strobe_byte", 32'(last_valid_byte), 32'hA5);
        check("t1_valid_cycles", 32'(valid_cnt - snap), 32'd1);
        check("t1_count", 32'(bus.rx_count), 32'd1);
        check("t1_ferr", 32'(bus.frame_err), 32'd0);
        check("t1_state", 32'(bus.state), 32'(IDLE));

        // 2: back-to-back frames from a fresh reset
        do_reset();
        snap = valid_cnt;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(BIT);
        check("t2_valid_cycles", 32'(valid_cnt - snap), 32'd2);
        check("t2_byte", 32'(bus.rx_byte), 32'hFF);
        check("t2_count", 32'(bus.rx_count), 32'd2);

        // 3: 5-cycle low glitch
        snap = valid_cnt;
        rx_serial = 1'b0;
        idle(5);
        rx_serial = 1'b1;
        idle(1);
        check("t3_busy_during", 32'(bus.busy), 32'd1);
        idle(BIT);
        check("t3_state", 32'(bus.state), 32'(IDLE));
        check("t3_valid_cycles", 32'(valid_cnt - snap), 32'd0);
        check("t3_ferr", 32'(bus.frame_err), 32'd0);
        check("t3_count", 32'(bus.rx_count), 32'd2);

        // 4: bad stop bit, clear, then clear colliding with a new error
        snap = valid_cnt;
        send_frame(8'h55, 1'b0);
        idle(BIT);
        check("t4_ferr_set", 32'(bus.frame_err), 32'd1);
        check("t4_byte_kept", 32'(bus.rx_byte), 32'hFF);
        check("t4_count_kept", 32'(bus.rx_count), 32'd2);
        check("t4_no_valid", 32'(valid_cnt - snap), 32'd0);
        bus.err_clr = 1'b1;
        idle(1);
        bus.err_clr = 1'b0;
        idle(1);
        check("t4_ferr_clr", 32'(bus.frame_err), 32'd0);
        found = 1'b0;
        fork
            send_frame(8'h55, 1'b0);
            begin
                for (int i = 0; i < 400 && !found; i++) begin
                    @(negedge clk);
                    if (bus.state === STOP) found = 1'b1;
                end
                if (found) begin
                    idle(BIT - 1);
                    bus.err_clr = 1'b1;
                    idle(1);
                    bus.err_clr = 1'b0;
                end
            end
        join
        check("t4_stop_reached", 32'(found), 32'd1);
        idle(BIT);
        check("t4_set_wins", 32'(bus.frame_err), 32'd1);
        check("t4_count_kept2", 32'(bus.rx_count), 32'd2);

        // 5: 256 frames wrap the counter
        do_reset();
        snap = valid_cnt;
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i) ^ 8'h5A, 1'b1);
        end
        idle(BIT);
        check("t5_valid_cycles", 32'(valid_cnt - snap), 32'd256);
        check("t5_count_wrap", 32'(bus.rx_count), 32'd0);
        check("t5_byte", 32'(bus.rx_byte), 32'hA5);
        check("t5_ferr", 32'(bus.frame_err), 32'd0);

        // 6: reset in the middle of the data bits of 0x81
        rx_serial = 1'b0;
        idle(BIT);
        rx_serial = 1'b1;
        idle(BIT);
        rx_serial = 1'b0;
        idle(BIT);
        idle(BIT / 2);
        check("t6_in_data", 32'(bus.state), 32'(DATA));
        reset_n = 1'b0;
        rx_serial = 1'b1;
        #1;
        check("t6_rst_byte", 32'(bus.rx_byte), 32'h00);
        check("t6_rst_state", 32'(bus.state), 32'(IDLE));
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        idle(3);
        reset_n = 1'b1;
        idle(2 * BIT);
        check("t6_no_spurious", 32'(valid_cnt - snap), 32'd256);
        send_frame(8'h18, 1'b1);
        idle(BIT);
        check("t6_byte", 32'(bus.rx_byte), 32'h18);
        check("t6_count", 32'(bus.rx_count), 32'd1);
        check("t6_valid_cycles", 32'(valid_cnt - snap), 32'd257);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
